elevator_controller_nfloor: RTL

//  Parametrised N-floor elevator controller; successor to the fixed 3-floor controller.

---
 rtl/elevator_pkg.sv | 27 ++
 rtl/elevator_request_table.sv | 76 +++++++
 rtl/elevator_controller_nfloor.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types and request-vector helpers for the N-floor elevator controller.
package elevator_pkg;

    localparam int MAX_FLOORS = 64;

    typedef enum logic [1:0] {IDLE, MOVING, DOOR} state_t;
    typedef enum logic {UP, DOWN} dir_t;

    function automatic logic any_above(input logic [MAX_FLOORS-1:0] vec, input int floor);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (i > floor && vec[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic any_below(input logic [MAX_FLOORS-1:0] vec, input int floor);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (i < floor && vec[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/elevator_request_table.sv
// Latched hall-up, hall-down and cab requests, plus queries about the floor the FSM is looking at.
module elevator_request_table
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 4,
    parameter int FLOOR_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_up,
    input  logic [NUM_FLOORS-1:0] call_down,
    input  logic [NUM_FLOORS-1:0] select_floor,
    input  logic                  door_open,
    input  logic [FLOOR_W-1:0]    door_floor,
    input  logic [FLOOR_W-1:0]    sel_floor,
    input  logic                  stop_dir_up,
    input  logic                  clr_en,
    input  logic                  clr_dir_up,
    input  logic                  clr_both,
    output logic [NUM_FLOORS-1:0] pend_up,
    output logic [NUM_FLOORS-1:0] pend_down,
    output logic [NUM_FLOORS-1:0] pend_cab,
    output logic                  req_above,
    output logic                  req_below,
    output logic                  req_here,
    output logic                  req_stop,
    output logic                  call_at_door
);

    localparam logic [NUM_FLOORS-1:0] ONE     = {{(NUM_FLOORS-1){1'b0}}, 1'b1};
    localparam logic [NUM_FLOORS-1:0] UP_MASK = ~(ONE << (NUM_FLOORS-1));
    localparam logic [NUM_FLOORS-1:0] DN_MASK = ~ONE;

    logic [NUM_FLOORS-1:0] pend_up_q, pend_down_q, pend_cab_q;
    logic [NUM_FLOORS-1:0] door_oh, sel_oh, blk, req_all;
    logic [NUM_FLOORS-1:0] set_up, set_dn, set_cab, clr_up, clr_dn, clr_cab;

    assign door_oh = ONE << door_floor;
    assign sel_oh  = ONE << sel_floor;

    // A press at the open-door floor is absorbed by the dwell timer instead of being latched.
    assign blk     = door_open ? door_oh : '0;
    assign set_up  = call_up & UP_MASK & ~blk;
    assign set_dn  = call_down & DN_MASK & ~blk;
    assign set_cab = select_floor & ~blk;
    assign call_at_door = door_open &&
        |(((call_up & UP_MASK) | (call_down & DN_MASK) | select_floor) & door_oh);

    assign clr_cab = clr_en ? sel_oh : '0;
    assign clr_up  = (clr_en && (clr_dir_up || clr_both)) ? sel_oh : '0;
    assign clr_dn  = (clr_en && (!clr_dir_up || clr_both)) ? sel_oh : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_up_q   <= '0;
            pend_down_q <= '0;
            pend_cab_q  <= '0;
        end else begin
            pend_up_q   <= (pend_up_q | set_up) & ~clr_up;
            pend_down_q <= (pend_down_q | set_dn) & ~clr_dn;
            pend_cab_q  <= (pend_cab_q | set_cab) & ~clr_cab;
        end
    end

    assign pend_up   = pend_up_q;
    assign pend_down = pend_down_q;
    assign pend_cab  = pend_cab_q;

    assign req_all   = pend_up_q | pend_down_q | pend_cab_q;
    assign req_above = any_above(MAX_FLOORS'(req_all), int'(sel_floor));
    assign req_below = any_below(MAX_FLOORS'(req_all), int'(sel_floor));
    assign req_here  = |(req_all & sel_oh);
    assign req_stop  = |(pend_cab_q & sel_oh) |
                       (stop_dir_up ? |(pend_up_q & sel_oh) : |(pend_down_q & sel_oh));

endmodule

// File: rtl/elevator_controller_nfloor.sv
// N-floor SCAN elevator: FSM, travel counter, door dwell counter and direction register.
module elevator_controller_nfloor
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 4,
    parameter int FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_up,
    input  logic [NUM_FLOORS-1:0] call_down,
    input  logic [NUM_FLOORS-1:0] select_floor,
    input  logic                  door_hold,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  door_open,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic [NUM_FLOORS-1:0] pend_up,
    output logic [NUM_FLOORS-1:0] pend_down,
    output logic [NUM_FLOORS-1:0] pend_cab,
    output logic [1:0]            dbg_state_o
);

    localparam int TW = $clog2(TRAVEL_CYCLES);
    localparam int DW = $clog2(DOOR_CYCLES);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS-1);
    localparam logic [TW-1:0]      TRAVEL_LAST = TW'(TRAVEL_CYCLES-1);
    localparam logic [DW-1:0]      DOOR_LAST   = DW'(DOOR_CYCLES-1);

    state_t               state_q, state_d;
    dir_t                 dir_q, dir_d;
    logic [FLOOR_W-1:0]   floor_q, floor_d, next_floor, sel_floor;
    logic [TW-1:0]        travel_q, travel_d;
    logic [DW-1:0]        dwell_q, dwell_d;
    logic                 door_open_q, moving_up_q, moving_down_q;
    logic                 arrive, ahead, behind, clr_en, clr_both;
    logic                 req_above, req_below, req_here, req_stop, call_at_door;

    assign arrive = (state_q == MOVING) && (travel_q == TRAVEL_LAST);

    always_comb begin
        next_floor = floor_q;
        if (dir_q == UP && floor_q != TOP_FLOOR) next_floor = floor_q + FLOOR_W'(1);
        if (dir_q == DOWN && floor_q != '0)      next_floor = floor_q - FLOOR_W'(1);
    end

    // The table is queried at the floor being arrived at, otherwise at the current floor.
    assign sel_floor = arrive ? next_floor : floor_q;
    assign ahead     = (dir_q == UP) ? req_above : req_below;
    assign behind    = (dir_q == UP) ? req_below : req_above;

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        floor_d  = floor_q;
        travel_d = travel_q;
        dwell_d  = dwell_q;
        case (state_q)
            IDLE: begin
                if (req_here) begin
                    state_d = DOOR;
                    dwell_d = DOOR_LAST;
                end else if (req_above && (dir_q == UP || !req_below)) begin
                    state_d  = MOVING;
                    dir_d    = UP;
                    travel_d = '0;
                end else if (req_below) begin
                    state_d  = MOVING;
                    dir_d    = DOWN;
                    travel_d = '0;
                end
            end
            MOVING: begin
                if (arrive) begin
                    floor_d  = next_floor;
                    travel_d = '0;
                    if (req_stop || !ahead) begin
                        state_d = DOOR;
                        dwell_d = DOOR_LAST;
                    end
                end else begin
                    travel_d = travel_q + TW'(1);
                end
            end
            DOOR: begin
                if (door_hold || call_at_door) begin
                    dwell_d = DOOR_LAST;
                end else if (dwell_q != '0) begin
                    dwell_d = dwell_q - DW'(1);
                end else if (ahead) begin
                    state_d  = MOVING;
                    travel_d = '0;
                end else if (behind) begin
                    state_d  = MOVING;
                    dir_d    = (dir_q == UP) ? DOWN : UP;
                    travel_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (floor_d == TOP_FLOOR) dir_d = DOWN;
        if (floor_d == '0)        dir_d = UP;
    end

    // Door entry clears the served requests; with nothing beyond, both hall lamps go out.
    assign clr_en   = (state_d == DOOR) && (state_q != DOOR);
    assign clr_both = !((dir_d == UP) ? req_above : req_below);

    elevator_request_table #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_table (
        .clk          (clk),
        .rst          (rst),
        .call_up      (call_up),
        .call_down    (call_down),
        .select_floor (select_floor),
        .door_open    (door_open_q),
        .door_floor   (floor_q),
        .sel_floor    (sel_floor),
        .stop_dir_up  (dir_q == UP),
        .clr_en       (clr_en),
        .clr_dir_up   (dir_d == UP),
        .clr_both     (clr_both),
        .pend_up      (pend_up),
        .pend_down    (pend_down),
        .pend_cab     (pend_cab),
        .req_above    (req_above),
        .req_below    (req_below),
        .req_here     (req_here),
        .req_stop     (req_stop),
        .call_at_door (call_at_door)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            dir_q         <= UP;
            floor_q       <= '0;
            travel_q      <= '0;
            dwell_q       <= '0;
            door_open_q   <= 1'b0;
            moving_up_q   <= 1'b0;
            moving_down_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            floor_q       <= floor_d;
            travel_q      <= travel_d;
            dwell_q       <= dwell_d;
            door_open_q   <= (state_d == DOOR);
            moving_up_q   <= (state_d == MOVING) && (dir_d == UP);
            moving_down_q <= (state_d == MOVING) && (dir_d == DOWN);
        end
    end

    assign current_floor = floor_q;
    assign door_open     = door_open_q;
    assign moving_up     = moving_up_q;
    assign moving_down   = moving_down_q;
    assign dbg_state_o   = state_q;

endmodule
